// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage initiator for the byte-addressed Data_mem; splits misaligned accesses.
// Build option MISALIGN_TRAP_EN: misaligned requests answer with misalign_err instead of being split.
module load_store_unit #(
  parameter int XLEN      = 32,
  parameter int WORD_STEP = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_done,
  output logic [XLEN-1:0] resp_rdata,
  output logic [XLEN-1:0] mem_addr,
  output logic            MemWrite,
  output logic            MemRead,
  output logic            HalfOperation,
  output logic            ByteOperation,
  output logic [XLEN-1:0] data_write,
  input  logic [XLEN-1:0] data_read
`ifdef MISALIGN_TRAP_EN
  ,
  output logic            misalign_err
`endif
);

`ifdef MISALIGN_TRAP_EN
  typedef enum logic [1:0] {IDLE} state_e;
`else
  typedef enum logic [1:0] {IDLE, LD_HI, ST_BYTES} state_e;
`endif

  state_e          state_q, state_d;
  logic            resp_done_q, resp_done_d;
  logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
  logic            isByte, isHalf, misaligned;
  logic [XLEN-1:0] alignedShifted;

`ifdef MISALIGN_TRAP_EN
  logic            misalign_err_q, misalign_err_d;
`else
  // addr_q holds word address A for a split load, the start byte address for a split store
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] loWord_q, loWord_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      offset_q, offset_d;
  logic [1:0]      size_q, size_d;
  logic            isUnsigned_q, isUnsigned_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [1:0]      last_q, last_d;
  logic [XLEN-1:0] splitShifted;
`endif

  function automatic logic [XLEN-1:0] extendLoad(input logic [XLEN-1:0] raw,
                                                 input logic [1:0] size,
                                                 input logic uns);
    logic [XLEN-1:0] res;
    case (size)
      2'b00:   res = {{(XLEN-8){raw[7] & ~uns}}, raw[7:0]};
      2'b01:   res = {{(XLEN-16){raw[15] & ~uns}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign isByte         = (req_size == 2'b00);
  assign isHalf         = (req_size == 2'b01);
  assign misaligned     = (isHalf & req_addr[0]) | (req_size[1] & (req_addr[1:0] != 2'b00));
  assign alignedShifted = data_read >> {req_addr[1:0], 3'b000};
`ifndef MISALIGN_TRAP_EN
  assign splitShifted   = XLEN'({data_read, loWord_q} >> {offset_q, 3'b000});
`endif

  assign req_ready  = (state_q == IDLE);
  assign resp_done  = resp_done_q;
  assign resp_rdata = resp_rdata_q;
`ifdef MISALIGN_TRAP_EN
  assign misalign_err = misalign_err_q;
`endif

  always_comb begin
    state_d       = state_q;
    resp_done_d   = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    mem_addr      = '0;
    MemWrite      = 1'b0;
    MemRead       = 1'b0;
    HalfOperation = 1'b0;
    ByteOperation = 1'b0;
    data_write    = '0;
`ifdef MISALIGN_TRAP_EN
    misalign_err_d = 1'b0;
`else
    addr_d        = addr_q;
    loWord_d      = loWord_q;
    wdata_d       = wdata_q;
    offset_d      = offset_q;
    size_d        = size_q;
    isUnsigned_d  = isUnsigned_q;
    cnt_d         = cnt_q;
    last_d        = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (misaligned) begin
`ifdef MISALIGN_TRAP_EN
            resp_done_d    = 1'b1;
            misalign_err_d = 1'b1;
`else
            if (!req_we) begin
              MemRead      = 1'b1;
              mem_addr     = {req_addr[XLEN-1:2], 2'b00};
              addr_d       = {req_addr[XLEN-1:2], 2'b00};
              loWord_d     = data_read;
              offset_d     = req_addr[1:0];
              size_d       = req_size;
              isUnsigned_d = req_unsigned;
              state_d      = LD_HI;
            end else begin
              // The split store writes nothing in the accept cycle; bytes follow one per cycle
              addr_d  = req_addr;
              wdata_d = req_wdata;
              cnt_d   = 2'd0;
              last_d  = isHalf ? 2'd1 : 2'd3;
              state_d = ST_BYTES;
            end
`endif
          end else if (req_we) begin
            MemWrite      = 1'b1;
            HalfOperation = isHalf;
            ByteOperation = isByte;
            mem_addr      = req_addr;
            data_write    = req_wdata;
            resp_done_d   = 1'b1;
          end else begin
            MemRead      = 1'b1;
            mem_addr     = {req_addr[XLEN-1:2], 2'b00};
            resp_rdata_d = extendLoad(alignedShifted, req_size, req_unsigned);
            resp_done_d  = 1'b1;
          end
        end
      end
`ifndef MISALIGN_TRAP_EN
      LD_HI: begin
        MemRead      = 1'b1;
        mem_addr     = addr_q + XLEN'(WORD_STEP);
        resp_rdata_d = extendLoad(splitShifted, size_q, isUnsigned_q);
        resp_done_d  = 1'b1;
        state_d      = IDLE;
      end
      ST_BYTES: begin
        MemWrite      = 1'b1;
        ByteOperation = 1'b1;
        mem_addr      = addr_q + {{(XLEN-2){1'b0}}, cnt_q};
        data_write    = {{(XLEN-8){1'b0}}, wdata_q[{cnt_q, 3'b000} +: 8]};
        if (cnt_q == last_q) begin
          resp_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
    // Reset must stop an in-progress split store before the next edge commits another byte
    if (rst) begin
      mem_addr      = '0;
      MemWrite      = 1'b0;
      MemRead       = 1'b0;
      HalfOperation = 1'b0;
      ByteOperation = 1'b0;
      data_write    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      resp_done_q  <= 1'b0;
      resp_rdata_q <= '0;
`ifdef MISALIGN_TRAP_EN
      misalign_err_q <= 1'b0;
`else
      addr_q       <= '0;
      loWord_q     <= '0;
      wdata_q      <= '0;
      offset_q     <= 2'd0;
      size_q       <= 2'd0;
      isUnsigned_q <= 1'b0;
      cnt_q        <= 2'd0;
      last_q       <= 2'd0;
`endif
    end else begin
      state_q      <= state_d;
      resp_done_q  <= resp_done_d;
      resp_rdata_q <= resp_rdata_d;
`ifdef MISALIGN_TRAP_EN
      misalign_err_q <= misalign_err_d;
`else
      addr_q       <= addr_d;
      loWord_q     <= loWord_d;
      wdata_q      <= wdata_d;
      offset_q     <= offset_d;
      size_q       <= size_d;
      isUnsigned_q <= isUnsigned_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
`endif
    end
  end

endmodule
